// File: rtl/jpeg_pkg.sv
// Shared JPEG encoder types: coefficient/symbol formats, zigzag scan tables
// and the run-length stage state encoding.
package jpeg_pkg;

    localparam int COEF_BITS = 12;
    localparam int RUN_BITS  = 4;
    localparam int SIZE_BITS = 4;

    typedef logic signed [COEF_BITS-1:0] coef_t;
    typedef logic signed [COEF_BITS:0]   diff_t;

    typedef struct packed {
        logic [RUN_BITS-1:0]  run;
        logic [SIZE_BITS-1:0] size;
        diff_t                amp;
        logic                 is_dc;
        logic                 last;
    } rle_sym_t;

    // Row/column of the k-th coefficient in JPEG zigzag order
    localparam logic [2:0] ZIGZAG_ROW [0:63] = '{
        0, 0, 1, 2, 1, 0, 0, 1, 2, 3, 4, 3, 2, 1, 0, 0,
        1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, 0, 1, 2, 3,
        4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 2, 3, 4, 5, 6,
        7, 7, 6, 5, 4, 3, 4, 5, 6, 7, 7, 6, 5, 6, 7, 7
    };
    localparam logic [2:0] ZIGZAG_COL [0:63] = '{
        0, 1, 0, 0, 1, 2, 3, 2, 1, 0, 0, 1, 2, 3, 4, 5,
        4, 3, 2, 1, 0, 0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4,
        3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3,
        2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 5, 6, 7, 7, 6, 7
    };

    localparam rle_sym_t SYM_ZRL = '{run: {RUN_BITS{1'b1}}, size: '0, amp: '0,
                                     is_dc: 1'b0, last: 1'b0};
    localparam rle_sym_t SYM_EOB = '{run: '0, size: '0, amp: '0,
                                     is_dc: 1'b0, last: 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DC,
        ST_SCAN,
        ST_DRAIN
    } rle_state_t;

endpackage

// File: rtl/magnitude_category.sv
// JPEG magnitude category: number of significant bits in |value|.
module magnitude_category #(
    parameter int IN_W   = 13,
    parameter int SIZE_W = 4
) (
    input  logic signed [IN_W-1:0]   value,
    output logic        [SIZE_W-1:0] category
);

    logic [IN_W-1:0] mag;

    always_comb begin
        mag      = value[IN_W-1] ? IN_W'(-value) : IN_W'(value);
        category = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (mag[i]) category = SIZE_W'(i + 1);
        end
    end

endmodule

// File: rtl/zigzag_rle.sv
// Zigzag scan and run-length coder: turns one quantized 8x8 block into
// DC-difference / AC (run, size, amplitude) symbols for the Huffman stage.
module zigzag_rle
    import jpeg_pkg::*;
#(
    parameter int COEF_W = COEF_BITS,
    parameter int RUN_W  = RUN_BITS,
    parameter int SIZE_W = SIZE_BITS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   blk_valid,
    output logic                                   blk_ready,
    input  logic signed [0:7][0:7][COEF_W-1:0]     blk_in,
    input  logic                                   dc_clear,
    output logic                                   sym_valid,
    input  logic                                   sym_ready,
    output logic        [RUN_W-1:0]                sym_run,
    output logic        [SIZE_W-1:0]               sym_size,
    output logic signed [COEF_W:0]                 sym_amp,
    output logic                                   sym_is_dc,
    output logic                                   sym_last
);

    rle_state_t         state;
    coef_t [0:7][0:7]   blk_q;
    coef_t              pred;
    logic [5:0]         k;
    logic [5:0]         run_cnt;
    rle_sym_t           sym_q;
    logic               sym_valid_q;

    coef_t              cur_coef;
    diff_t              cur_ext;
    diff_t              dc_diff;
    diff_t              cat_in;
    logic [SIZE_BITS-1:0] cat_out;
    logic               out_free;

    assign cur_coef = blk_q[ZIGZAG_ROW[k]][ZIGZAG_COL[k]];
    assign cur_ext  = diff_t'(cur_coef);
    assign dc_diff  = diff_t'(blk_q[0][0]) - diff_t'(pred);
    assign cat_in   = (state == ST_DC) ? dc_diff : cur_ext;
    assign out_free = !sym_valid_q || sym_ready;

    magnitude_category #(
        .IN_W   (COEF_BITS + 1),
        .SIZE_W (SIZE_BITS)
    ) u_cat (
        .value    (cat_in),
        .category (cat_out)
    );

    // One zigzag position is consumed per cycle whenever the output register
    // can take a new symbol; a ZRL leaves k in place so the same coefficient
    // is revisited with the run reduced by 16.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            blk_q       <= '0;
            pred        <= '0;
            k           <= '0;
            run_cnt     <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
        end else begin
            if (dc_clear) pred <= '0;
            case (state)
                ST_IDLE: begin
                    if (blk_valid) begin
                        blk_q <= blk_in;
                        state <= ST_DC;
                    end
                end
                ST_DC: begin
                    sym_q       <= '{run: '0, size: cat_out, amp: dc_diff,
                                     is_dc: 1'b1, last: 1'b0};
                    sym_valid_q <= 1'b1;
                    pred        <= blk_q[0][0];
                    k           <= 6'd1;
                    run_cnt     <= '0;
                    state       <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (out_free) begin
                        sym_valid_q <= 1'b0;
                        if (cur_coef == '0 && k != 6'd63) begin
                            run_cnt <= run_cnt + 6'd1;
                            k       <= k + 6'd1;
                        end else if (cur_coef != '0 && run_cnt >= 6'd16) begin
                            sym_q       <= SYM_ZRL;
                            sym_valid_q <= 1'b1;
                            run_cnt     <= run_cnt - 6'd16;
                        end else if (cur_coef != '0) begin
                            sym_q       <= '{run: run_cnt[RUN_BITS-1:0], size: cat_out,
                                             amp: cur_ext, is_dc: 1'b0,
                                             last: (k == 6'd63)};
                            sym_valid_q <= 1'b1;
                            run_cnt     <= '0;
                            if (k == 6'd63) state <= ST_DRAIN;
                            else            k     <= k + 6'd1;
                        end else begin
                            sym_q       <= SYM_EOB;
                            sym_valid_q <= 1'b1;
                            state       <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (sym_ready) begin
                        sym_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign blk_ready = (state == ST_IDLE);
    assign sym_valid = sym_valid_q;
    assign sym_run   = sym_q.run;
    assign sym_size  = sym_q.size;
    assign sym_amp   = sym_q.amp;
    assign sym_is_dc = sym_q.is_dc;
    assign sym_last  = sym_q.last;

endmodule

// File: tb/tb_zigzag_rle.sv
// Self-checking bench for zigzag_rle: directed and random blocks checked
// against a symbol-list reference model built from the JPEG coding rules.
module tb_zigzag_rle;

    localparam int COEF_W = 12;
    localparam int RUN_W  = 4;
    localparam int SIZE_W = 4;

    logic                               clk = 1'b0;
    logic                               rst;
    logic                               blk_valid;
    logic                               blk_ready;
    logic signed [0:7][0:7][COEF_W-1:0] blk_in;
    logic                               dc_clear;
    logic                               sym_valid;
    logic                               sym_ready;
    logic        [RUN_W-1:0]            sym_run;
    logic        [SIZE_W-1:0]           sym_size;
    logic signed [COEF_W:0]             sym_amp;
    logic                               sym_is_dc;
    logic                               sym_last;

    zigzag_rle #(.COEF_W(COEF_W), .RUN_W(RUN_W), .SIZE_W(SIZE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_in    (blk_in),
        .dc_clear  (dc_clear),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_run   (sym_run),
        .sym_size  (sym_size),
        .sym_amp   (sym_amp),
        .sym_is_dc (sym_is_dc),
        .sym_last  (sym_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int run;
        int size;
        int amp;
        int is_dc;
        int last;
    } exp_sym_t;

    exp_sym_t exp_q[$];
    int       cur_blk [8][8];
    int       zz_row  [64];
    int       zz_col  [64];
    int       tb_pred;
    int       vectors;
    int       miscompares;

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int cat_of(input int v);
        int m;
        int c;
        m = (v < 0) ? -v : v;
        c = 0;
        while (m > 0) begin
            m = m >> 1;
            c++;
        end
        return c;
    endfunction

    // Zigzag order from anti-diagonals: even diagonals walk up-right, odd down-left
    task automatic build_zigzag();
        int n;
        int lo;
        int hi;
        n = 0;
        for (int d = 0; d < 15; d++) begin
            lo = (d > 7) ? d - 7 : 0;
            hi = (d < 7) ? d : 7;
            if (d % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz_row[n] = r; zz_col[n] = d - r; n++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz_row[n] = r; zz_col[n] = d - r; n++;
                end
            end
        end
    endtask

    task automatic push_sym(input int run, input int size, input int amp,
                            input int is_dc, input int last);
        exp_sym_t s;
        s.run = run; s.size = size; s.amp = amp; s.is_dc = is_dc; s.last = last;
        exp_q.push_back(s);
    endtask

    task automatic build_expected();
        int diff;
        int last_nz;
        int run;
        int v;
        exp_q.delete();
        diff = cur_blk[0][0] - tb_pred;
        push_sym(0, cat_of(diff), diff, 1, 0);
        tb_pred = cur_blk[0][0];
        last_nz = 0;
        for (int i = 1; i < 64; i++)
            if (cur_blk[zz_row[i]][zz_col[i]] != 0) last_nz = i;
        run = 0;
        for (int i = 1; i <= last_nz; i++) begin
            v = cur_blk[zz_row[i]][zz_col[i]];
            if (v == 0) run++;
            else begin
                while (run > 15) begin
                    push_sym(15, 0, 0, 0, 0);
                    run -= 16;
                end
                push_sym(run, cat_of(v), v, 0, (i == 63) ? 1 : 0);
                run = 0;
            end
        end
        if (last_nz < 63) push_sym(0, 0, 0, 0, 1);
    endtask

    task automatic clear_blk();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) cur_blk[r][c] = 0;
    endtask

    task automatic random_blk(input int density);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                if ($urandom_range(0, 15) < density) begin
                    if ($urandom_range(0, 3) == 0) cur_blk[r][c] = int'($urandom_range(0, 4095)) - 2048;
                    else cur_blk[r][c] = int'($urandom_range(0, 30)) - 15;
                    if (cur_blk[r][c] == 0) cur_blk[r][c] = 1;
                end else cur_blk[r][c] = 0;
            end
        cur_blk[0][0] = int'($urandom_range(0, 4095)) - 2048;
    endtask

    task automatic pulse_dc_clear();
        dc_clear = 1'b1;
        @(negedge clk);
        dc_clear = 1'b0;
        tb_pred = 0;
    endtask

    task automatic drive_block();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) blk_in[r][c] = COEF_W'(cur_blk[r][c]);
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: 5-cycle stall after 2 symbols then toggling
    task automatic applyStimulus(input int mode);
        int budget;
        int got;
        int stall;
        int n_exp;
        build_expected();
        n_exp = exp_q.size();
        budget = 0;
        while (!blk_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("blk_ready_idle", blk_ready, 1);
        drive_block();
        checkOutput("blk_ready_busy", blk_ready, 0);
        got = 0; stall = 0; budget = 0;
        while (exp_q.size() > 0 && budget < 400) begin
            case (mode)
                0: sym_ready = 1'b1;
                1: sym_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (got == 2 && stall < 5) begin
                        sym_ready = 1'b0;
                        stall++;
                    end else if (got > 2) sym_ready = (budget % 2 == 0);
                    else sym_ready = 1'b1;
                end
            endcase
            if (sym_valid) begin
                checkOutput("sym_run",   sym_run,         exp_q[0].run);
                checkOutput("sym_size",  sym_size,        exp_q[0].size);
                checkOutput("sym_amp",   $signed(sym_amp), exp_q[0].amp);
                checkOutput("sym_is_dc", sym_is_dc,       exp_q[0].is_dc);
                checkOutput("sym_last",  sym_last,        exp_q[0].last);
                if (sym_ready) begin
                    void'(exp_q.pop_front());
                    got++;
                end
            end
            @(negedge clk);
            budget++;
        end
        checkOutput("symbols_received", got, n_exp);
        sym_ready = 1'b1;
        checkOutput("no_extra_symbol", sym_valid, 0);
        checkOutput("idle_after_last", blk_ready, 1);
    endtask

    initial begin
        vectors = 0; miscompares = 0; tb_pred = 0;
        rst = 1'b1; blk_valid = 1'b0; dc_clear = 1'b0; sym_ready = 1'b0; blk_in = '0;
        build_zigzag();
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_blk_ready", blk_ready, 1);
        checkOutput("reset_sym_valid", sym_valid, 0);
        checkOutput("reset_sym_run",   sym_run, 0);
        checkOutput("reset_sym_size",  sym_size, 0);
        checkOutput("reset_sym_amp",   $signed(sym_amp), 0);
        checkOutput("reset_sym_is_dc", sym_is_dc, 0);
        checkOutput("reset_sym_last",  sym_last, 0);
        rst = 1'b0;
        @(negedge clk);

        clear_blk();
        applyStimulus(0);

        clear_blk(); cur_blk[0][0] = 5;
        applyStimulus(0);
        clear_blk(); cur_blk[0][0] = 3;
        applyStimulus(0);
        pulse_dc_clear();
        applyStimulus(0);

        pulse_dc_clear();
        clear_blk(); cur_blk[0][1] = 3; cur_blk[1][0] = -7;
        applyStimulus(0);

        clear_blk(); cur_blk[7][7] = -1;
        applyStimulus(0);

        clear_blk(); cur_blk[0][0] = -2048;
        applyStimulus(0);
        cur_blk[0][0] = 2047; cur_blk[7][6] = -2048; cur_blk[2][5] = 2047;
        applyStimulus(0);

        random_blk(6);
        applyStimulus(0);
        applyStimulus(2);

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 4) == 0) pulse_dc_clear();
            random_blk(int'($urandom_range(0, 10)));
            applyStimulus(int'($urandom_range(0, 1)));
        end

        // Reset in the middle of a dense block's symbol stream
        begin
            int got;
            int budget;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) cur_blk[r][c] = r * 8 + c + 1;
            sym_ready = 1'b1;
            drive_block();
            got = 0; budget = 0;
            while (!(got >= 3 && sym_valid) && budget < 50) begin
                if (sym_valid) got++;
                @(negedge clk);
                budget++;
            end
            checkOutput("valid_before_reset", sym_valid, 1);
            sym_ready = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            checkOutput("midblock_reset_valid", sym_valid, 0);
            checkOutput("midblock_reset_ready", blk_ready, 1);
            rst = 1'b0;
            tb_pred = 0;
            @(negedge clk);
            clear_blk(); cur_blk[0][0] = 9; cur_blk[3][4] = -100;
            applyStimulus(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/zigzag_rle.md
Name: zigzag_rle

Overview:
Stage directly downstream of quantization in the JPEG encoder.
- Captures one 8x8 block of quantized signed coefficients.
- Walks the block in standard JPEG zigzag order.
- Emits a stream of entropy-coding symbols (run, size, amplitude) through a valid/ready handshake to the Huffman stage.
- DC is coded as the difference from the previous block's DC. AC is run-length coded with ZRL and EOB.

Parameters:
COEF_W, 12, width of each signed quantized coefficient
RUN_W, 4, width of the zero-run field (max run 15)
SIZE_W, 4, width of the magnitude-category field

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
blk_valid  in  1  input block present
blk_ready  out  1  stage can accept a block
blk_in  in  [0:7][0:7] x COEF_W signed  quantized block, row-major [row][col]
dc_clear  in  1  single-cycle pulse: zero the DC predictor (new scan/component)
sym_valid  out  1  symbol present
sym_ready  in  1  downstream accepts symbol
sym_run  out  RUN_W  zeros preceding this coefficient (AC only)
sym_size  out  SIZE_W  JPEG magnitude category of sym_amp
sym_amp  out  COEF_W+1 signed  coefficient value (AC) or DC difference
sym_is_dc  out  1  symbol is the DC difference
sym_last  out  1  final symbol of the block

Behaviour:
Reset:
- Synchronous, active-high: rst sampled high at a clk edge.
- After reset: state IDLE, blk_ready=1, sym_valid=0, all symbol fields 0, DC predictor 0, run counter 0, scan index 0.
- Reset mid-block discards the captured block and any held symbol. sym_valid is low the cycle after rst.

Handshake:
- A transfer occurs on any edge where valid&&ready.
- While sym_valid=1 and sym_ready=0, all sym_* outputs hold stable.
- The output register reloads when empty or accepted in the same cycle, so back-to-back symbols flow at 1/cycle.

FSM:
- IDLE:
  - blk_ready=1.
  - On blk_valid, latch all 64 coefficients, go DC.
- DC:
  - Next cycle load the DC symbol: diff = blk[0][0] - pred, computed at COEF_W+1 bits, no overflow possible.
  - Fields: run=0, size=cat(diff), amp=diff, is_dc=1, last=0.
  - pred <= blk[0][0] when the DC symbol is loaded.
  - k=1, run=0, go SCAN.
- SCAN, one zigzag index k per cycle when the output register is free:
  - coef[k]==0 and k<63: run++, k++, no symbol.
  - coef[k]!=0 and run>=16: emit ZRL (run=15, size=0, amp=0), run-=16, k unchanged.
  - coef[k]!=0 and run<16: emit (run, cat(coef), coef), run=0. If k==63, last=1 and go IDLE after acceptance; else k++.
  - coef[k]==0 and k==63: emit EOB (run=0, size=0, amp=0, last=1), go IDLE after acceptance.
  - ZRLs are never emitted for trailing zeros; EOB covers them.
- blk_ready=1 only in IDLE, so there is no overlap between blocks.
  - The new block is accepted the cycle after the last symbol is accepted.

Magnitude category:
- cat(v) = number of bits in |v|.
- cat(0)=0, cat(±1)=1, cat(±2..3)=2, cat(±4..7)=3, ..., up to 12.

dc_clear:
- Sets pred=0 on that edge.
- If it coincides with DC symbol load, the DC load wins: pred=blk[0][0].
- Intended use is between blocks only.

Latency and throughput:
- First symbol is valid 2 cycles after block acceptance.
- Worst-case block duration is 1 + 63 + ZRL count + 1 cycles with no backpressure.

Decomposition:
- jpeg_pkg (shared package):
  - coef_t (signed COEF_W).
  - rle_sym_t struct {run, size, amp, is_dc, last}.
  - ZIGZAG_ROW/ZIGZAG_COL constant arrays [0:63].
  - ZRL/EOB encodings.
  - State enum.
- Sub-module magnitude_category:
  - Combinational, signed COEF_W+1 in, SIZE_W out.
  - Shared with the future Huffman stage.
- Top contains the block register, FSM, index/run counters, DC predictor and output register.

Test Plan:
- Reset, then an all-zero block -> DC (run0, size0, amp0, is_dc=1), then EOB (0,0,0, last=1); exactly 2 symbols.
- Block A DC=5, then block B DC=3 (all AC zero) -> A: size3 amp=+5; B: size2 amp=-2. After dc_clear, block B again -> amp=+3, size2.
- blk[0][1]=3, blk[1][0]=-7, rest 0, pred 0 -> DC(0,0,0), (0,2,+3), (0,3,-7), EOB last=1. Confirms zigzag k=1→[0][1], k=2→[1][0].
- Only blk[7][7]=-1 (k=63) -> DC, three ZRL (15,0,0), then (14,1,-1) last=1; no EOB.
- Backpressure: hold sym_ready=0 for 5 cycles mid-stream -> outputs stable and no symbol lost or duplicated. Then toggle sym_ready 1/0 and check the sequence is identical to the unstalled run.
- Assert rst during SCAN with sym_valid=1 -> next cycle sym_valid=0, blk_ready=1. The next block's DC diff is computed against pred=0.
